// File: rtl/wash_pkg.sv
// Shared phase codes, phase durations and state type for the washer sequencer.
// Phase codes are also the state encoding, so the phase output is the state register.
package wash_pkg;

  localparam logic [2:0] PhIdle   = 3'd0;
  localparam logic [2:0] PhSelect = 3'd1;
  localparam logic [2:0] PhFill   = 3'd2;
  localparam logic [2:0] PhWash   = 3'd3;
  localparam logic [2:0] PhRinse  = 3'd4;
  localparam logic [2:0] PhSpin   = 3'd5;
  localparam logic [2:0] PhDone   = 3'd6;

  localparam logic [3:0] FillSecs  = 4'd2;
  localparam logic [3:0] RinseSecs = 4'd3;
  localparam logic [3:0] SpinSecs  = 4'd4;

  typedef enum logic [2:0] {
    StIdle   = PhIdle,
    StSelect = PhSelect,
    StFill   = PhFill,
    StWash   = PhWash,
    StRinse  = PhRinse,
    StSpin   = PhSpin,
    StDone   = PhDone
  } wash_state_e;

  // Seconds spent in a phase; non-run phases have no countdown.
  function automatic logic [3:0] phase_secs(input wash_state_e ph, input logic [3:0] prog);
    logic [3:0] secs;
    secs = 4'd0;
    case (ph)
      StFill:  secs = FillSecs;
      StWash:  secs = prog;
      StRinse: secs = RinseSecs;
      StSpin:  secs = SpinSecs;
      default: secs = 4'd0;
    endcase
    return secs;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable 4-bit seconds down-counter; expires on the tick that sees a count of 1.
// A load overrides the tick, so the owner reloads on expiry and the count never reaches 0.
module wash_phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       tick_i,
  output logic [3:0] count_o,
  output logic       expire_o
);

  logic [3:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q > 4'd1)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == 4'd1);

endmodule

// File: rtl/wash_sequencer.sv
// Washer program select and phase scheduler: counts key presses into a program, arms after
// an idle window of ticks, then runs fill, wash, rinse and spin off the 1 Hz tick.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned ArmSecs = 5,
  parameter int unsigned MaxProg = 9
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_1hz_i,
  input  logic       key_pulse_i,
  input  logic       cancel_pulse_i,
  output logic [3:0] prog_o,
  output logic [2:0] phase_o,
  output logic [3:0] remain_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  wash_state_e state_d, state_q;
  logic [3:0]  prog_d, prog_q;
  logic [3:0]  arm_d, arm_q;
  logic        err_d, err_q;
  logic        busy_q, done_q;

  logic        tmr_load;
  logic [3:0]  tmr_load_val;
  logic        tmr_expire;
  logic [3:0]  tmr_count;

  // The timer count doubles as the remain display: arm window in SELECT, phase time when running.
  wash_phase_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tick_i     (tick_1hz_i & ~cancel_pulse_i),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    prog_d       = prog_q;
    arm_d        = arm_q;
    err_d        = err_q;
    tmr_load     = 1'b0;
    tmr_load_val = 4'd0;

    if (cancel_pulse_i) begin
      state_d      = StIdle;
      prog_d       = 4'd0;
      arm_d        = 4'd0;
      err_d        = 1'b0;
      tmr_load     = 1'b1;
      tmr_load_val = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_pulse_i) begin
            state_d      = StSelect;
            prog_d       = 4'd1;
            arm_d        = 4'd0;
            tmr_load     = 1'b1;
            tmr_load_val = 4'(ArmSecs);
          end
        end
        StSelect: begin
          if (key_pulse_i) begin
            // A key restarts the arm window even if a tick lands in the same cycle.
            arm_d        = 4'd0;
            tmr_load     = 1'b1;
            tmr_load_val = 4'(ArmSecs);
            if (prog_q < 4'(MaxProg)) begin
              prog_d = prog_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (tick_1hz_i) begin
            if (arm_q == 4'(ArmSecs - 1)) begin
              state_d      = StFill;
              arm_d        = 4'd0;
              tmr_load     = 1'b1;
              tmr_load_val = FillSecs;
            end else begin
              arm_d = arm_q + 4'd1;
            end
          end
        end
        StFill, StWash, StRinse, StSpin: begin
          if (tmr_expire) begin
            // Run phase codes are consecutive, ending in DONE after SPIN.
            state_d      = wash_state_e'(state_q + 3'd1);
            tmr_load     = 1'b1;
            tmr_load_val = phase_secs(state_d, prog_q);
          end
        end
        StDone: begin
          if (key_pulse_i) begin
            state_d      = StSelect;
            prog_d       = 4'd1;
            arm_d        = 4'd0;
            err_d        = 1'b0;
            tmr_load     = 1'b1;
            tmr_load_val = 4'(ArmSecs);
          end
        end
        default: begin
          state_d      = StIdle;
          prog_d       = 4'd0;
          arm_d        = 4'd0;
          err_d        = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      prog_q  <= 4'd0;
      arm_q   <= 4'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      arm_q   <= arm_d;
      err_q   <= err_d;
      busy_q  <= (state_d == StFill) || (state_d == StWash) ||
                 (state_d == StRinse) || (state_d == StSpin);
      done_q  <= (state_d == StDone);
    end
  end

  assign prog_o   = prog_q;
  assign phase_o  = state_q;
  assign remain_o = tmr_count;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed scenarios plus random pulses against a behavioural model.
module tb_wash_sequencer;

  localparam int unsigned Arm  = 5;
  localparam int unsigned MaxP = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       key = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] prog;
  logic [2:0] phase;
  logic [3:0] remain;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  // Model state: phase number, program, seconds left, idle ticks since last key, error flag.
  int m_phase, m_prog, m_rem, m_arm, m_err;

  always #5 clk = ~clk;

  wash_sequencer #(
    .ArmSecs (Arm),
    .MaxProg (MaxP)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tick_1hz_i     (tick),
    .key_pulse_i    (key),
    .cancel_pulse_i (cancel),
    .prog_o         (prog),
    .phase_o        (phase),
    .remain_o       (remain),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dur(input int ph, input int pr);
    int secs [7] = '{0, 0, 2, 0, 3, 4, 0};
    return (ph == 3) ? pr : secs[ph];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prog = 0; m_rem = 0; m_arm = 0; m_err = 0;
  endtask

  task automatic model_step(input bit k, input bit t, input bit c);
    if (c) begin
      model_reset();
    end else if (m_phase == 0 || m_phase == 6) begin
      if (k) begin
        m_phase = 1; m_prog = 1; m_arm = 0; m_err = 0; m_rem = Arm;
      end
    end else if (m_phase == 1) begin
      if (k) begin
        m_arm = 0;
        m_rem = Arm;
        if (m_prog < MaxP) m_prog++;
        else m_err = 1;
      end else if (t) begin
        m_arm++;
        if (m_arm == Arm) begin
          m_phase = 2; m_arm = 0; m_rem = 2;
        end else begin
          m_rem = Arm - m_arm;
        end
      end
    end else if (t) begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase++;
        m_rem = dur(m_phase, m_prog);
      end
    end
  endtask

  task automatic check_all(input string w);
    check({w, ".phase"}, int'(phase), m_phase);
    check({w, ".prog"}, int'(prog), m_prog);
    check({w, ".remain"}, int'(remain), m_rem);
    check({w, ".busy"}, int'(busy), (m_phase >= 2 && m_phase <= 5) ? 1 : 0);
    check({w, ".done"}, int'(done), (m_phase == 6) ? 1 : 0);
    check({w, ".err"}, int'(err), m_err);
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input bit k, input bit t, input bit c, input string w);
    key = k; tick = t; cancel = c;
    model_step(k, t, c);
    @(negedge clk);
    check_all(w);
    key = 1'b0; tick = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, "sel");
    repeat (5) cyc(1'b0, 1'b1, 1'b0, "arm");
    check("arm.prog3", int'(prog), 3);
    check("arm.fill", int'(phase), 2);
    check("arm.rem2", int'(remain), 2);
    check("arm.busy", int'(busy), 1);

    repeat (12) cyc(1'b0, 1'b1, 1'b0, "run");
    check("run.done_phase", int'(phase), 6);
    check("run.done", int'(done), 1);
    check("run.rem0", int'(remain), 0);

    cyc(1'b1, 1'b0, 1'b0, "done_key");
    check("done_key.phase", int'(phase), 1);
    check("done_key.prog", int'(prog), 1);

    cyc(1'b0, 1'b0, 1'b1, "cancel0");
    repeat (10) cyc(1'b1, 1'b0, 1'b0, "ovf");
    check("ovf.prog", int'(prog), 9);
    check("ovf.err", int'(err), 1);
    cyc(1'b0, 1'b0, 1'b1, "ovf_cancel");
    check("ovf_cancel.err", int'(err), 0);

    cyc(1'b1, 1'b0, 1'b0, "kt");
    repeat (4) cyc(1'b0, 1'b1, 1'b0, "kt_win");
    cyc(1'b1, 1'b1, 1'b0, "kt_same");
    check("kt_same.phase", int'(phase), 1);
    check("kt_same.prog", int'(prog), 2);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, "kt_wait");
    check("kt_wait.phase", int'(phase), 1);
    cyc(1'b0, 1'b1, 1'b0, "kt_arm");
    check("kt_arm.phase", int'(phase), 2);

    repeat (2) cyc(1'b0, 1'b1, 1'b0, "to_wash");
    cyc(1'b1, 1'b0, 1'b0, "wash_key");
    check("wash_key.phase", int'(phase), 3);
    check("wash_key.prog", int'(prog), 2);
    check("wash_key.rem", int'(remain), 2);

    repeat (6) cyc(1'b0, 1'b1, 1'b0, "to_spin");
    check("spin.phase", int'(phase), 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async.phase", int'(phase), 0);
    check("async.prog", int'(prog), 0);
    check("async.remain", int'(remain), 0);
    check("async.busy", int'(busy), 0);
    check("async.done", int'(done), 0);
    check("async.err", int'(err), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all("post_reset");

    cyc(1'b1, 1'b0, 1'b0, "ck_sel");
    cyc(1'b1, 1'b0, 1'b1, "ck_both");
    check("ck_both.phase", int'(phase), 0);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30,
          $urandom_range(0, 999) < 8, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
